// File: rtl/dmem_dma.sv
// Single-channel word copy engine driving the data-memory port.
// Optional fill mode (fill_mode/fill_val ports) is enabled by defining DMEM_DMA_FILL_EN.
module dmem_dma #(
  parameter int unsigned LEN_W   = 7,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
`ifdef DMEM_DMA_FILL_EN
  input  logic             fill_mode,
  input  logic [31:0]      fill_val,
`endif
  input  logic [31:0]      mem_rd,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] count
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone, StErr} state_e;

  localparam logic [LEN_W:0]   MaxLen = (LEN_W + 1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] One    = LEN_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      s_ptr_q, s_ptr_d;
  logic [31:0]      d_ptr_q, d_ptr_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [31:0]      data_q, data_d;
`ifdef DMEM_DMA_FILL_EN
  logic             fill_q, fill_d;
`endif

  // Address bits [1:0] are dropped on load; keep them visibly consumed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src[1:0], dst[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      s_ptr_q  <= '0;
      d_ptr_q  <= '0;
      remain_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
`ifdef DMEM_DMA_FILL_EN
      fill_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_ptr_q  <= s_ptr_d;
      d_ptr_q  <= d_ptr_d;
      remain_q <= remain_d;
      count_q  <= count_d;
      data_q   <= data_d;
`ifdef DMEM_DMA_FILL_EN
      fill_q   <= fill_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    s_ptr_d  = s_ptr_q;
    d_ptr_d  = d_ptr_q;
    remain_d = remain_q;
    count_d  = count_q;
    data_d   = data_q;
`ifdef DMEM_DMA_FILL_EN
    fill_d   = fill_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ({1'b0, len} > MaxLen) begin
            state_d = StErr;
          end else if (len == '0) begin
            count_d = '0;
            state_d = StDone;
          end else begin
            s_ptr_d  = {src[31:2], 2'b00};
            d_ptr_d  = {dst[31:2], 2'b00};
            remain_d = len;
            count_d  = '0;
`ifdef DMEM_DMA_FILL_EN
            fill_d   = fill_mode;
            // Fill reuses the holding register so WRITE needs no mode mux.
            data_d   = fill_val;
            state_d  = fill_mode ? StWrite : StRead;
`else
            state_d  = StRead;
`endif
          end
        end
      end
      StRead: begin
        data_d  = mem_rd;
        s_ptr_d = s_ptr_q + 32'd4;
        state_d = StWrite;
      end
      StWrite: begin
        d_ptr_d  = d_ptr_q + 32'd4;
        count_d  = count_q + One;
        remain_d = remain_q - One;
        if (remain_q == One) begin
          state_d = StDone;
        end else begin
`ifdef DMEM_DMA_FILL_EN
          state_d = fill_q ? StWrite : StRead;
`else
          state_d = StRead;
`endif
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    unique case (state_q)
      StRead: begin
        mem_a = s_ptr_q;
      end
      StWrite: begin
        mem_we = 1'b1;
        mem_a  = d_ptr_q;
        mem_wd = data_q;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q == StRead) || (state_q == StWrite);
  assign done  = (state_q == StDone);
  assign err   = (state_q == StErr);
  assign count = count_q;

endmodule

// File: tb/tb_dmem_dma.sv
// Scoreboard bench for dmem_dma: stimulus pushes expected accesses and completion
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_dmem_dma;
  localparam int LEN_W   = 7;
  localparam int MAX_LEN = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
`ifdef DMEM_DMA_FILL_EN
  logic             fill_mode;
  logic [31:0]      fill_val;
`endif
  logic [31:0]      mem_rd;
  logic             mem_we;
  logic [31:0]      mem_a, mem_wd;
  logic             busy, done, err;
  logic [LEN_W-1:0] count;

  always #5 clk = ~clk;

  dmem_dma #(.LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src       (src),
    .dst       (dst),
    .len       (len),
`ifdef DMEM_DMA_FILL_EN
    .fill_mode (fill_mode),
    .fill_val  (fill_val),
`endif
    .mem_rd    (mem_rd),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  // 64-word data memory; bench preload goes through the same write process.
  logic [31:0] ram     [64];
  logic [31:0] exp_mem [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_d;

  assign mem_rd = ram[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) ram[mem_a[7:2]] <= mem_wd;
    else if (pre_we) ram[pre_idx] <= pre_d;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } acc_t;

  typedef struct {
    logic is_err;
    int   c;
    int   cnt;
  } ev_t;

  acc_t acc_q[$];
  ev_t  ev_q[$];
  int   errs       = 0;
  int   checks     = 0;
  int   last_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    acc_t a;
    ev_t  e;
    if (busy === 1'b1) begin
      if (acc_q.size() == 0) begin
        chk("pending_access", 32'(acc_q.size()), 32'd1);
      end else begin
        a = acc_q.pop_front();
        chk("acc_we", 32'(mem_we), 32'(a.we));
        chk("acc_addr", mem_a, a.a);
        if (a.we) chk("acc_wdata", mem_wd, a.d);
        chk("acc_cycle", 32'(cyc), 32'(a.c));
      end
    end else if (mem_we !== 1'b0) begin
      chk("we_while_not_busy", 32'(mem_we), 32'd0);
    end
    if (done === 1'b1 || err === 1'b1) begin
      if (ev_q.size() == 0) begin
        chk("pending_event", 32'(ev_q.size()), 32'd1);
      end else begin
        e = ev_q.pop_front();
        chk("ev_is_err", 32'(err), 32'(e.is_err));
        chk("ev_is_done", 32'(done), 32'(!e.is_err));
        chk("ev_cycle", 32'(cyc), 32'(e.c));
        chk("ev_count", 32'(count), 32'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    pre_we  = 1'b1;
    pre_idx = 6'(idx);
    pre_d   = v;
    exp_mem[idx] = v;
    tick();
    pre_we = 1'b0;
  endtask

  // Push expectations for one command (only those at relative cycle <= stop), then pulse start.
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n,
                       input logic fm, input logic [31:0] fv, input int stop);
    int          t0, si, di;
    logic [31:0] sa, da, w;
    t0 = cyc;
    si = int'(s[7:2]);
    di = int'(d[7:2]);
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    w  = '0;
    if (n > MAX_LEN) begin
      if (stop >= 1) ev_q.push_back('{1'b1, t0 + 1, last_count});
    end else if (n == 0) begin
      last_count = 0;
      if (stop >= 1) ev_q.push_back('{1'b0, t0 + 1, 0});
    end else if (fm) begin
      for (int k = 0; k < n; k++) begin
        if (k + 1 <= stop) begin
          acc_q.push_back('{1'b1, da + 32'(4 * k), fv, t0 + k + 1});
          exp_mem[(di + k) % 64] = fv;
        end
      end
      if (n + 1 <= stop) ev_q.push_back('{1'b0, t0 + n + 1, n});
      last_count = n;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (2 * k + 1 <= stop) begin
          w = exp_mem[(si + k) % 64];
          acc_q.push_back('{1'b0, sa + 32'(4 * k), 32'd0, t0 + 2 * k + 1});
        end
        if (2 * k + 2 <= stop) begin
          acc_q.push_back('{1'b1, da + 32'(4 * k), w, t0 + 2 * k + 2});
          exp_mem[(di + k) % 64] = w;
        end
      end
      if (2 * n + 1 <= stop) ev_q.push_back('{1'b0, t0 + 2 * n + 1, n});
      last_count = n;
    end
    src   = s;
    dst   = d;
    len   = LEN_W'(n);
`ifdef DMEM_DMA_FILL_EN
    fill_mode = fm;
    fill_val  = fv;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_wait(input int budget, input string name);
    int i;
    i = 0;
    while ((acc_q.size() != 0 || ev_q.size() != 0) && i < budget) begin
      tick();
      i++;
    end
    checks++;
    if (acc_q.size() != 0 || ev_q.size() != 0) begin
      errs++;
      $display("FAIL %s_timeout: pending accesses=%0d events=%0d, required 0", name,
               acc_q.size(), ev_q.size());
      acc_q.delete();
      ev_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic mem_check(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== exp_mem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    src     = '0;
    dst     = '0;
    len     = '0;
    pre_we  = 1'b0;
    pre_idx = '0;
    pre_d   = '0;
`ifdef DMEM_DMA_FILL_EN
    fill_mode = 1'b0;
    fill_val  = '0;
`endif
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 64; i++) poke(i, 32'h1000_0000 + 32'(i));
    poke(0, 32'h11);
    poke(1, 32'h22);
    poke(2, 32'h33);
    poke(3, 32'h44);

    // Basic copy: done in cycle 9, writes in cycles 2,4,6,8.
    issue(32'h00, 32'h40, 4, 1'b0, 32'h0, 1000);
    finish_wait(50, "copy");
    chk("copy_ram16", ram[16], 32'h11);
    chk("copy_ram17", ram[17], 32'h22);
    chk("copy_ram18", ram[18], 32'h33);
    chk("copy_ram19", ram[19], 32'h44);
    chk("copy_count", 32'(count), 32'd4);

    issue(32'h00, 32'h00, 0, 1'b0, 32'h0, 1000);
    finish_wait(20, "len0");
    chk("len0_count", 32'(count), 32'd0);

    issue(32'h00, 32'h80, 65, 1'b0, 32'h0, 1000);
    finish_wait(20, "len65");
    mem_check("len65_mem_unchanged");

    // Full-depth self copy: done in cycle 129.
    issue(32'h00, 32'h00, 64, 1'b0, 32'h0, 1000);
    finish_wait(200, "len64");
    mem_check("len64_mem_unchanged");
    chk("len64_count", 32'(count), 32'd64);

    // Unaligned addresses plus an extra start in cycle 3 that must be ignored.
    issue(32'h03, 32'h42, 2, 1'b0, 32'h0, 1000);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_wait(30, "unaligned");
    mem_check("unaligned_mem");

    // Reset in cycle 5 of an 8-word copy.
    issue(32'h00, 32'h80, 8, 1'b0, 32'h0, 5);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_count = 0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_acc_left", 32'(acc_q.size()), 32'd0);
    issue(32'h00, 32'h80, 1, 1'b0, 32'h0, 1000);
    finish_wait(20, "after_reset");
    mem_check("after_reset_mem");

    // Forward-overlapping copy propagates word 0.
    poke(0, 32'hA);
    poke(1, 32'hB);
    poke(2, 32'hC);
    poke(3, 32'hD);
    issue(32'h00, 32'h04, 3, 1'b0, 32'h0, 1000);
    finish_wait(30, "overlap");
    chk("overlap_w0", ram[0], 32'hA);
    chk("overlap_w1", ram[1], 32'hA);
    chk("overlap_w2", ram[2], 32'hA);
    chk("overlap_w3", ram[3], 32'hA);

`ifdef DMEM_DMA_FILL_EN
    issue(32'h00, 32'h20, 3, 1'b1, 32'hDEAD_BEEF, 1000);
    finish_wait(20, "fill");
    chk("fill_w8", ram[8], 32'hDEAD_BEEF);
    chk("fill_w9", ram[9], 32'hDEAD_BEEF);
    chk("fill_w10", ram[10], 32'hDEAD_BEEF);
    chk("fill_count", 32'(count), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
